// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer controller:
// field widths, entry bit positions, PC slicing and the controller state encoding.
package btb_pkg;

    localparam int BTB_IDX_W = 5;
    localparam int BTB_TAG_W = 9;
    localparam int BTB_TGT_W = 16;
    localparam int BTB_ENT_W = 26;
    localparam int BTB_PC_W  = 16;
    localparam int BTB_DEPTH = 1 << BTB_IDX_W;

    // Entry layout: {valid, tag, target}
    localparam int ENT_VALID_BIT = 25;
    localparam int ENT_TAG_MSB   = 24;
    localparam int ENT_TAG_LSB   = 16;
    localparam int ENT_TGT_MSB   = 15;
    localparam int ENT_TGT_LSB   = 0;

    // PC slicing: low bits index the table, the next bits form the tag
    localparam int PC_IDX_MSB = 4;
    localparam int PC_IDX_LSB = 0;
    localparam int PC_TAG_MSB = 13;
    localparam int PC_TAG_LSB = 5;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } btb_state_t;

    // Build a valid entry for a taken branch at pc jumping to target
    function automatic logic [BTB_ENT_W-1:0] make_entry(
        input logic [BTB_PC_W-1:0]  pc,
        input logic [BTB_TGT_W-1:0] target
    );
        logic [BTB_ENT_W-1:0] ent;
        ent = '0;
        ent[ENT_VALID_BIT]           = 1'b1;
        ent[ENT_TAG_MSB:ENT_TAG_LSB] = pc[PC_TAG_MSB:PC_TAG_LSB];
        ent[ENT_TGT_MSB:ENT_TGT_LSB] = target;
        return ent;
    endfunction

endpackage

// File: rtl/btb_sweep.sv
// Invalidation sweep FSM: walks every table index once after reset or flush,
// supplying the sweep write address and the busy indication.
module btb_sweep
    import btb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    output logic                 busy,
    output logic [BTB_IDX_W-1:0] sweep_idx
);

    localparam logic [BTB_IDX_W-1:0] LAST_IDX = BTB_IDX_W'(BTB_DEPTH - 1);

    btb_state_t           state_reg, state_next;
    logic [BTB_IDX_W-1:0] sweep_cnt_reg, sweep_cnt_next;

    // State and sweep counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            sweep_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sweep_cnt_reg <= sweep_cnt_next;
        end
    end

    // Next state: a flush always (re)starts the sweep from index 0
    always_comb begin
        state_next     = state_reg;
        sweep_cnt_next = sweep_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                if (flush) begin
                    sweep_cnt_next = '0;
                end else if (sweep_cnt_reg == LAST_IDX) begin
                    state_next     = ST_RUN;
                    sweep_cnt_next = '0;
                end else begin
                    sweep_cnt_next = sweep_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next     = ST_INIT;
                    sweep_cnt_next = '0;
                end
            end
            default: begin
                state_next     = ST_INIT;
                sweep_cnt_next = '0;
            end
        endcase
    end

    assign busy      = (state_reg == ST_INIT);
    assign sweep_idx = sweep_cnt_reg;

endmodule

// File: rtl/btb_ctrl.sv
// Branch target buffer controller: lookup, update and invalidation sweep
// in front of an external 32 x 26 synchronous-read memory.
// Optional macro BTB_FWD_EN: forward same-cycle write data to a colliding
// lookup; without it a colliding lookup is reported as a miss.
module btb_ctrl
    import btb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_vld,
    input  logic [BTB_PC_W-1:0]  fetch_pc,
    output logic                 pred_vld,
    output logic                 pred_hit,
    output logic [BTB_TGT_W-1:0] pred_target,
    input  logic                 upd_vld,
    input  logic [BTB_PC_W-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic [BTB_TGT_W-1:0] upd_target,
    input  logic                 flush,
    output logic                 busy,
    output logic [BTB_IDX_W-1:0] mem_ra,
    input  logic [BTB_ENT_W-1:0] mem_rd,
    output logic [BTB_IDX_W-1:0] mem_wa,
    output logic [BTB_ENT_W-1:0] mem_wd,
    output logic                 mem_web,
    output logic                 mem_cs
);

    logic                 sweep_busy;
    logic [BTB_IDX_W-1:0] sweep_idx;

    logic                 wr_en;
    logic [BTB_IDX_W-1:0] wr_idx;
    logic [BTB_ENT_W-1:0] wr_data;
    logic                 collision;

    logic                 fetch_vld_reg;
    logic [BTB_TAG_W-1:0] tag_reg;
    logic                 busy_reg;
    logic                 collision_reg;

    logic [BTB_ENT_W-1:0] rd_ent;
    logic                 hit_block;

    // Upper PC bits lie outside both index and tag
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, fetch_pc[BTB_PC_W-1:PC_TAG_MSB+1], upd_pc[BTB_PC_W-1:PC_TAG_MSB+1]};

    btb_sweep u_sweep (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .busy      (sweep_busy),
        .sweep_idx (sweep_idx)
    );

    // Write source: sweep clears during INIT; in RUN a resolved branch writes unless flushed
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        if (sweep_busy) begin
            wr_en  = 1'b1;
            wr_idx = sweep_idx;
        end else if (upd_vld && !flush) begin
            wr_en  = 1'b1;
            wr_idx = upd_pc[PC_IDX_MSB:PC_IDX_LSB];
            if (upd_taken) begin
                wr_data = make_entry(upd_pc, upd_target);
            end
        end
    end

    assign collision = fetch_vld & wr_en & (fetch_pc[PC_IDX_MSB:PC_IDX_LSB] == wr_idx);

    assign mem_ra  = fetch_pc[PC_IDX_MSB:PC_IDX_LSB];
    assign mem_wa  = wr_idx;
    assign mem_wd  = wr_data;
    assign mem_web = ~wr_en;
    assign mem_cs  = fetch_vld | wr_en | sweep_busy;
    assign busy    = sweep_busy;

    // Capture request-cycle context to pair with the read data one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_vld_reg <= 1'b0;
            tag_reg       <= '0;
            busy_reg      <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            fetch_vld_reg <= fetch_vld;
            tag_reg       <= fetch_pc[PC_TAG_MSB:PC_TAG_LSB];
            busy_reg      <= sweep_busy;
            collision_reg <= collision;
        end
    end

`ifdef BTB_FWD_EN
    logic [BTB_ENT_W-1:0] fwd_data_reg;

    // Hold the write data of a colliding cycle so the lookup sees the new entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_data_reg <= '0;
        end else begin
            fwd_data_reg <= wr_data;
        end
    end

    assign rd_ent    = collision_reg ? fwd_data_reg : mem_rd;
    assign hit_block = 1'b0;
`else
    assign rd_ent    = mem_rd;
    assign hit_block = collision_reg;
`endif

    assign pred_vld    = fetch_vld_reg;
    assign pred_hit    = fetch_vld_reg & rd_ent[ENT_VALID_BIT]
                       & (rd_ent[ENT_TAG_MSB:ENT_TAG_LSB] == tag_reg)
                       & ~busy_reg & ~hit_block;
    assign pred_target = pred_hit ? rd_ent[ENT_TGT_MSB:ENT_TGT_LSB] : '0;

endmodule

// File: tb/tb_btb_ctrl.sv
// Testbench for btb_ctrl with a behavioural memory and a table-level reference model.
// Honours BTB_FWD_EN for the collision expectation.
module tb_btb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_vld = 1'b0;
    logic [15:0] fetch_pc = '0;
    logic        pred_vld, pred_hit;
    logic [15:0] pred_target;
    logic        upd_vld = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [4:0]  mem_ra, mem_wa;
    logic [25:0] mem_rd, mem_wd;
    logic        mem_web, mem_cs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btb_ctrl dut (
        .clk(clk), .rst(rst),
        .fetch_vld(fetch_vld), .fetch_pc(fetch_pc),
        .pred_vld(pred_vld), .pred_hit(pred_hit), .pred_target(pred_target),
        .upd_vld(upd_vld), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .flush(flush), .busy(busy),
        .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_web(mem_web), .mem_cs(mem_cs)
    );

    // Synchronous memory, one-cycle read, old data on same-address read/write
    logic [25:0] mem [0:31];
    logic [25:0] mem_rd_r = '0;
    assign mem_rd = mem_rd_r;
    always @(posedge clk) begin
        if (mem_cs) begin
            mem_rd_r <= mem[mem_ra];
            if (!mem_web) mem[mem_wa] <= mem_wd;
        end
    end

    // Write log
    int          wlog_idx[$];
    logic [25:0] wlog_dat[$];
    always @(posedge clk) begin
        if (!mem_web) begin
            wlog_idx.push_back(int'(mem_wa));
            wlog_dat.push_back(mem_wd);
        end
    end

    // Reference model: table of entries plus remaining sweep cycles
    bit          m_valid [32];
    int          m_tag   [32];
    logic [15:0] m_tgt   [32];
    int          init_left;
    bit          exp_vld, exp_hit, exp_busy;
    logic [15:0] exp_tgt;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
        end
    endtask

    // Apply one cycle of stimulus, advance the model, return at the following negedge
    task automatic drive(input bit fv, input logic [15:0] fpc, input bit uv, input logic [15:0] upc,
                         input bit ut, input logic [15:0] utgt, input bit fl);
        int fi, ui, ftag, utag;
        bit wr, coll;
        fetch_vld = fv; fetch_pc = fpc;
        upd_vld = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        flush = fl;
        fi   = int'(fpc) % 32;
        ui   = int'(upc) % 32;
        ftag = (int'(fpc) / 32) % 512;
        utag = (int'(upc) / 32) % 512;
        wr   = (init_left == 0) && uv && !fl;
        coll = fv && wr && (fi == ui);
        exp_vld = fv;
        exp_hit = 1'b0;
        exp_tgt = '0;
        if (fv && init_left == 0) begin
            if (coll) begin
`ifdef BTB_FWD_EN
                if (ut && utag == ftag) begin
                    exp_hit = 1'b1;
                    exp_tgt = utgt;
                end
`endif
            end else if (m_valid[fi] && m_tag[fi] == ftag) begin
                exp_hit = 1'b1;
                exp_tgt = m_tgt[fi];
            end
        end
        if (fl) begin
            model_clear();
            init_left = 32;
        end else if (init_left > 0) begin
            init_left--;
        end else if (wr) begin
            m_valid[ui] = ut;
            m_tag[ui]   = utag;
            m_tgt[ui]   = utgt;
        end
        exp_busy = (init_left > 0);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        fetch_vld = 1'b1; fetch_pc = 16'h0123;
        @(negedge clk);
        n_checks++;
        if (pred_vld !== 1'b0 || pred_hit !== 1'b0 || pred_target !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: vld=%0b hit=%0b tgt=%0h, expected 0 0 0", pred_vld, pred_hit, pred_target);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %0b, expected 1", busy);
        end
        fetch_vld = 1'b0;
        rst = 1'b0;
        wlog_idx.delete(); wlog_dat.delete();
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_busy cycle %0d: got %0b, expected 1", i, busy);
            end
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_done_busy: got %0b, expected 0", busy);
        end
        n_checks++;
        if (wlog_idx.size() != 32) begin
            n_fail++;
            $display("FAIL sweep_write_count: got %0d, expected 32", wlog_idx.size());
        end else begin
            for (int k = 0; k < 32; k++) begin
                n_checks++;
                if (wlog_idx[k] != k || wlog_dat[k] !== 26'h0) begin
                    n_fail++;
                    $display("FAIL sweep_write %0d: idx=%0d data=%0h, expected idx=%0d data=0", k, wlog_idx[k], wlog_dat[k], k);
                end
            end
        end
        $display("reset: sweep of 32 writes observed, busy=%0b", busy);
        model_clear();
        init_left = 0;
    endtask

    task automatic test_hit();
        drive(0, 16'h0, 1, 16'h0123, 1, 16'h4000, 0);
        drive(1, 16'h0123, 0, 16'h0, 0, 16'h0, 0);
        n_checks++;
        if (pred_vld !== 1'b1 || pred_hit !== 1'b1 || pred_target !== 16'h4000) begin
            n_fail++;
            $display("FAIL hit_0123: vld=%0b hit=%0b tgt=%0h, expected 1 1 4000", pred_vld, pred_hit, pred_target);
        end
        $display("hit: fetch 0123 -> hit=%0b tgt=%0h", pred_hit, pred_target);
    endtask

    task automatic test_tag_miss();
        drive(1, 16'h0523, 0, 16'h0, 0, 16'h0, 0);
        n_checks++;
        if (pred_vld !== 1'b1 || pred_hit !== 1'b0 || pred_target !== 16'h0) begin
            n_fail++;
            $display("FAIL tag_miss_0523: vld=%0b hit=%0b tgt=%0h, expected 1 0 0", pred_vld, pred_hit, pred_target);
        end
        $display("tag_miss: fetch 0523 -> hit=%0b tgt=%0h", pred_hit, pred_target);
    endtask

    task automatic test_not_taken();
        drive(0, 16'h0, 1, 16'h0123, 0, 16'h4000, 0);
        drive(1, 16'h0123, 0, 16'h0, 0, 16'h0, 0);
        n_checks++;
        if (pred_hit !== 1'b0 || pred_target !== 16'h0) begin
            n_fail++;
            $display("FAIL not_taken_0123: hit=%0b tgt=%0h, expected 0 0", pred_hit, pred_target);
        end
        $display("not_taken: fetch 0123 -> hit=%0b", pred_hit);
    endtask

    task automatic test_collision();
        logic        exp_h;
        logic [15:0] exp_t;
`ifdef BTB_FWD_EN
        exp_h = 1'b1; exp_t = 16'h1234;
`else
        exp_h = 1'b0; exp_t = 16'h0;
`endif
        drive(1, 16'h0044, 1, 16'h0044, 1, 16'h1234, 0);
        n_checks++;
        if (pred_hit !== exp_h || pred_target !== exp_t) begin
            n_fail++;
            $display("FAIL collision_0044: hit=%0b tgt=%0h, expected %0b %0h", pred_hit, pred_target, exp_h, exp_t);
        end
        $display("collision: fetch/update 0044 -> hit=%0b tgt=%0h", pred_hit, pred_target);
        drive(1, 16'h0044, 0, 16'h0, 0, 16'h0, 0);
        n_checks++;
        if (pred_hit !== 1'b1 || pred_target !== 16'h1234) begin
            n_fail++;
            $display("FAIL after_collision_0044: hit=%0b tgt=%0h, expected 1 1234", pred_hit, pred_target);
        end
    endtask

    task automatic test_flush();
        int n;
        drive(0, 16'h0, 1, 16'h0123, 1, 16'h4000, 0);
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 1);
        wlog_idx.delete(); wlog_dat.delete();
        for (int i = 0; i < 10; i++) begin
            drive(1, 16'h0123, 0, 16'h0, 0, 16'h0, 0);
            n_checks++;
            if (pred_hit !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_sweep %0d: hit=%0b busy=%0b, expected 0 1", i, pred_hit, busy);
            end
        end
        drive(1, 16'h0123, 1, 16'h0200, 1, 16'h7777, 1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            drive(1, 16'h0123, 1, 16'h0123, 1, 16'h5555, 0);
            n++;
            n_checks++;
            if (pred_hit !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_lookup %0d: hit=%0b, expected 0", n, pred_hit);
            end
        end
        n_checks++;
        if (n != 32) begin
            n_fail++;
            $display("FAIL flush_restart_len: got %0d cycles, expected 32", n);
        end
        n_checks++;
        if (wlog_idx.size() != 43) begin
            n_fail++;
            $display("FAIL flush_write_count: got %0d, expected 43", wlog_idx.size());
        end else begin
            for (int k = 0; k < 43; k++) begin
                n_checks++;
                if (wlog_idx[k] != ((k < 11) ? k : k - 11) || wlog_dat[k] !== 26'h0) begin
                    n_fail++;
                    $display("FAIL flush_write %0d: idx=%0d data=%0h, expected idx=%0d data=0",
                             k, wlog_idx[k], wlog_dat[k], (k < 11) ? k : k - 11);
                end
            end
        end
        drive(1, 16'h0123, 0, 16'h0, 0, 16'h0, 0);
        n_checks++;
        if (pred_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_dropped_update: hit=%0b, expected 0", pred_hit);
        end
        $display("flush: restart after %0d sweep cycles, %0d writes", n, wlog_idx.size());
    endtask

    task automatic test_rst_midsweep();
        int n;
        drive(0, 16'h0, 0, 16'h0, 0, 16'h0, 1);
        for (int i = 0; i < 5; i++) drive(1, 16'h0044, 0, 16'h0, 0, 16'h0, 0);
        rst = 1'b1;
        #2;
        n_checks++;
        if (pred_vld !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_midsweep: vld=%0b busy=%0b, expected 0 1", pred_vld, busy);
        end
        fetch_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        init_left = 32;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            idle();
            n++;
        end
        n_checks++;
        if (n != 32) begin
            n_fail++;
            $display("FAIL rst_midsweep_len: got %0d cycles, expected 32", n);
        end
        $display("rst_midsweep: sweep restarted, %0d cycles busy", n);
    endtask

    task automatic test_random();
        bit fv, uv, ut, fl;
        logic [15:0] fpc, upc, utgt;
        for (int c = 0; c < 400; c++) begin
            fv   = ($urandom_range(0, 9) < 7);
            uv   = ($urandom_range(0, 9) < 4);
            ut   = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 79) == 0);
            fpc  = 16'($urandom_range(0, 2) * 32 + $urandom_range(0, 3) + $urandom_range(0, 3) * 16384);
            upc  = 16'($urandom_range(0, 2) * 32 + $urandom_range(0, 3) + $urandom_range(0, 3) * 16384);
            utgt = 16'($urandom);
            drive(fv, fpc, uv, upc, ut, utgt, fl);
            n_checks++;
            if (pred_vld !== exp_vld || pred_hit !== exp_hit || pred_target !== exp_tgt || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL random %0d pc=%0h: vld/hit/tgt/busy=%0b/%0b/%0h/%0b, expected %0b/%0b/%0h/%0b",
                         c, fpc, pred_vld, pred_hit, pred_target, busy, exp_vld, exp_hit, exp_tgt, exp_busy);
            end
        end
        $display("random: 400 cycles compared against reference model");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 26'($urandom);
        model_clear();
        init_left = 32;
        test_reset();
        test_hit();
        test_tag_miss();
        test_not_taken();
        test_collision();
        test_flush();
        test_rst_midsweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/btb_ctrl.md
BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous reset, active-high.
REQ-003 SHALL have ports: fetch_vld  in  1  lookup request; fetch_pc  in  16  fetch word address.
REQ-004 SHALL have ports: pred_vld  out  1  prediction valid; pred_hit  out  1  BTB hit; pred_target  out  16  predicted target.
REQ-005 SHALL have ports: upd_vld  in  1  branch resolved; upd_pc  in  16  branch PC; upd_taken  in  1  outcome; upd_target  in  16  resolved target.
REQ-006 SHALL have ports: flush  in  1  invalidate all entries; busy  out  1  invalidation sweep active.
REQ-007 SHALL have memory-side ports: mem_ra  out  5; mem_rd  in  26; mem_wa  out  5; mem_wd  out  26; mem_web  out  1  write enable, active-low; mem_cs  out  1  chip select.

Function
REQ-008 SHALL use entry format: bit 25 valid, bits 24:16 tag (pc[13:5]), bits 15:0 target; index SHALL be pc[4:0].
REQ-009 SHALL implement states INIT and RUN; INIT SHALL write 26'h0 to index sweep_cnt each cycle, sweep_cnt 0..31, moving to RUN after index 31 (32 cycles).
REQ-010 SHALL assert busy exactly while in INIT.
REQ-011 SHALL, on flush in RUN, enter INIT with sweep_cnt=0; flush in INIT SHALL restart sweep_cnt at 0.
REQ-012 SHALL drive mem_ra = fetch_pc[4:0] combinationally; the memory read latency is 1 cycle.
REQ-013 SHALL assert pred_vld one cycle after fetch_vld, in any state.
REQ-014 SHALL set pred_hit = fetch_vld_q & rd.valid & (rd.tag == tag_q) & ~busy_q, where _q denotes the value registered in the request cycle.
REQ-015 SHALL drive pred_target = rd.target when pred_hit, else 16'h0.
REQ-016 SHALL, on upd_vld & upd_taken in RUN, write {1, upd_pc[13:5], upd_target} at upd_pc[4:0] in the same cycle.
REQ-017 SHALL, on upd_vld & ~upd_taken in RUN, write 26'h0 at upd_pc[4:0] in the same cycle.
REQ-018 SHALL drop updates during INIT, with no write and no queuing.
REQ-019 SHALL drive mem_web=0 only in a write cycle; otherwise mem_web=1, mem_wa=0, mem_wd=0.
REQ-020 SHALL drive mem_cs = fetch_vld | write cycle | INIT.
REQ-021 SHALL treat a collision as a read and a write to the same index in one cycle; behaviour on collision SHALL be per REQ-027/REQ-028.
REQ-022 SHALL treat flush and upd_vld in the same cycle as flush; the update is dropped.

Reset
REQ-023 SHALL, on rst, enter INIT with sweep_cnt=0 and busy=1.
REQ-024 SHALL, on rst, clear pred_vld, pred_hit, pred_target and all _q registers to 0.
REQ-025 SHALL, on rst asserted mid-sweep or mid-lookup, abort immediately and restart the full sweep after deassertion.

Configuration
REQ-026 SHALL compile write-to-read forwarding in or out with macro BTB_FWD_EN.
REQ-027 SHALL, with BTB_FWD_EN defined, register collision write data and use it in place of mem_rd for REQ-014/REQ-015.
REQ-028 SHALL, without BTB_FWD_EN, force pred_hit=0 on the cycle following a collision.

Structure
REQ-029 SHALL place in shared package btb_pkg: BTB_IDX_W=5, BTB_TAG_W=9, BTB_TGT_W=16, BTB_ENT_W=26, field bit positions, and the state encoding.
REQ-030 SHALL contain one natural sub-module, btb_sweep: the INIT counter/FSM supplying sweep write address and busy. The memory instance SHALL stay outside btb_ctrl.

Verification
REQ-031 SHALL verify: rst pulse -> busy=1 for 32 cycles, 32 writes of 0 at indices 0..31, then busy=0.
REQ-032 SHALL verify: update pc=16'h0123 taken target=16'h4000, then fetch 16'h0123 -> next cycle pred_hit=1, pred_target=16'h4000.
REQ-033 SHALL verify: same entry, fetch 16'h0523 (same index, tag differs) -> pred_hit=0, pred_target=0.
REQ-034 SHALL verify: update pc=16'h0123 not taken, then fetch 16'h0123 -> pred_hit=0.
REQ-035 SHALL verify: collision, fetch 16'h0044 with update 16'h0044 taken target 16'h1234 -> with BTB_FWD_EN hit=1, target=16'h1234; without it hit=0.
REQ-036 SHALL verify: flush at sweep index 10 and upd_vld during INIT -> sweep restarts at 0, no update write, all lookups miss until busy drops.
